// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmit and receive paths.
// Holds the tx state encoding, error codes and frame-level constants.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_FAIL
    } ps2_tx_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_NACK    = 2'd2
    } ps2_err_t;

    // Host frame as seen on ps2c: 8 data + parity + stop + device ACK
    localparam int PS2_FRAME_FALLS = 11;

    // Shift image {stop, odd parity, data}; bit 0 goes out first
    function automatic logic [9:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter for the PS/2 clock pad: the filtered level only changes after
// FILTER_LEN consecutive equal samples; fall_o strobes once per filtered 1->0.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ps2c_i,
    output logic ps2c_filt_o,
    output logic fall_o
);

    logic [FILTER_LEN-1:0] shift_reg;
    logic [FILTER_LEN-1:0] shift_next;
    logic                  filt_reg;
    logic                  filt_next;
    logic                  fall_reg;

    assign shift_next[0] = ps2c_i;

    genvar gi;
    generate
        for (gi = 1; gi < FILTER_LEN; gi++) begin : g_stage
            assign shift_next[gi] = shift_reg[gi-1];
        end
    endgenerate

    always_comb begin
        filt_next = filt_reg;
        if (&shift_reg) begin
            filt_next = 1'b1;
        end else if (~|shift_reg) begin
            filt_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_reg <= '1;
            filt_reg  <= 1'b1;
            fall_reg  <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            filt_reg  <= filt_next;
            fall_reg  <= filt_reg & ~filt_next;
        end
    end

    assign ps2c_filt_o = filt_reg;
    assign fall_o      = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start, data, parity, stop and ACK check,
// with watchdog and error reporting. Define PS2_TX_RETRY_EN to retry failed frames MAX_RETRIES times.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES     = 13000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8,
    parameter int MAX_RETRIES    = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    inout  wire        ps2d_io,
    inout  wire        ps2c_io,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] err_code_o,
    output logic       busy_o
);

    localparam int RTS_W  = $clog2(RTS_CYCLES) + 1;
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int EDGE_W = $clog2(PS2_FRAME_FALLS) + 1;

    localparam logic [RTS_W-1:0]  RTS_LOAD  = RTS_W'(RTS_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LOAD   = WD_W'(TIMEOUT_CYCLES);
    localparam logic [EDGE_W-1:0] LAST_DATA = EDGE_W'(PS2_FRAME_FALLS - 2);

    ps2_tx_state_t     state_reg, state_next;
    logic [RTS_W-1:0]  rts_cnt_reg, rts_cnt_next;
    logic [WD_W-1:0]   wd_reg, wd_next;
    logic [EDGE_W-1:0] edge_cnt_reg, edge_cnt_next;
    logic [9:0]        shift_reg, shift_next;
    logic [7:0]        data_reg, data_next;
    ps2_err_t          fail_code_reg, fail_code_next;
    ps2_err_t          err_code_reg, err_code_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

`ifdef PS2_TX_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRIES) + 1;
    logic [RETRY_W-1:0] retries_reg, retries_next;
`endif

    logic ps2c_filt;
    logic ps2c_fall;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .ps2c_i      (ps2c_io),
        .ps2c_filt_o (ps2c_filt),
        .fall_o      (ps2c_fall)
    );

    // Pads follow the registered state so a reset releases them on the very next cycle
    logic c_drive_low;
    logic d_drive;
    logic d_val;

    assign c_drive_low = (state_reg == ST_RTS);
    assign d_drive     = (state_reg == ST_START) || (state_reg == ST_DATA);
    assign d_val       = (state_reg == ST_DATA) ? shift_reg[0] : 1'b0;
    assign ps2c_io     = c_drive_low ? 1'b0 : 1'bz;
    assign ps2d_io     = d_drive ? d_val : 1'bz;

    always_comb begin
        state_next     = state_reg;
        rts_cnt_next   = rts_cnt_reg;
        wd_next        = wd_reg;
        edge_cnt_next  = edge_cnt_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        fail_code_next = fail_code_reg;
        err_code_next  = err_code_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retries_next   = retries_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (tx_valid_i) begin
                    data_next     = tx_data_i;
                    shift_next    = ps2_frame(tx_data_i);
                    rts_cnt_next  = RTS_LOAD;
                    edge_cnt_next = '0;
`ifdef PS2_TX_RETRY_EN
                    retries_next  = '0;
`endif
                    state_next    = ST_RTS;
                end
            end

            ST_RTS: begin
                if (rts_cnt_reg == '0) begin
                    wd_next    = WD_LOAD;
                    state_next = ST_START;
                end else begin
                    rts_cnt_next = rts_cnt_reg - RTS_W'(1);
                end
            end

            ST_START: begin
                if (ps2c_fall) begin
                    wd_next       = WD_LOAD;
                    edge_cnt_next = EDGE_W'(1);
                    state_next    = ST_DATA;
                end else if (wd_reg == '0) begin
                    fail_code_next = ERR_TIMEOUT;
                    state_next     = ST_FAIL;
                end else begin
                    wd_next = wd_reg - WD_W'(1);
                end
            end

            // Fall 1 already presented d0; falls 2..9 shift in d1..parity, fall 10 is the stop
            ST_DATA: begin
                if (ps2c_fall) begin
                    wd_next       = WD_LOAD;
                    edge_cnt_next = edge_cnt_reg + EDGE_W'(1);
                    if (edge_cnt_reg == LAST_DATA) begin
                        state_next = ST_ACK;
                    end else begin
                        shift_next = {1'b0, shift_reg[9:1]};
                    end
                end else if (wd_reg == '0) begin
                    fail_code_next = ERR_TIMEOUT;
                    state_next     = ST_FAIL;
                end else begin
                    wd_next = wd_reg - WD_W'(1);
                end
            end

            ST_ACK: begin
                if (ps2c_fall) begin
                    edge_cnt_next = edge_cnt_reg + EDGE_W'(1);
                    if (ps2d_io == 1'b0) begin
                        wd_next    = WD_LOAD;
                        state_next = ST_WAIT_IDLE;
                    end else begin
                        fail_code_next = ERR_NACK;
                        state_next     = ST_FAIL;
                    end
                end else if (wd_reg == '0) begin
                    fail_code_next = ERR_TIMEOUT;
                    state_next     = ST_FAIL;
                end else begin
                    wd_next = wd_reg - WD_W'(1);
                end
            end

            ST_WAIT_IDLE: begin
                if (ps2d_io && ps2c_filt) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else if (wd_reg == '0) begin
                    fail_code_next = ERR_TIMEOUT;
                    state_next     = ST_FAIL;
                end else begin
                    wd_next = wd_reg - WD_W'(1);
                end
            end

            // Lines are released here for one cycle before retrying or giving up
            ST_FAIL: begin
`ifdef PS2_TX_RETRY_EN
                if (retries_reg < RETRY_W'(MAX_RETRIES)) begin
                    retries_next  = retries_reg + RETRY_W'(1);
                    shift_next    = ps2_frame(data_reg);
                    rts_cnt_next  = RTS_LOAD;
                    edge_cnt_next = '0;
                    state_next    = ST_RTS;
                end else begin
                    err_next      = 1'b1;
                    err_code_next = fail_code_reg;
                    state_next    = ST_IDLE;
                end
`else
                err_next      = 1'b1;
                err_code_next = fail_code_reg;
                state_next    = ST_IDLE;
`endif
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg     <= ST_IDLE;
            rts_cnt_reg   <= '0;
            wd_reg        <= '0;
            edge_cnt_reg  <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            fail_code_reg <= ERR_NONE;
            err_code_reg  <= ERR_NONE;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retries_reg   <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            rts_cnt_reg   <= rts_cnt_next;
            wd_reg        <= wd_next;
            edge_cnt_reg  <= edge_cnt_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            fail_code_reg <= fail_code_next;
            err_code_reg  <= err_code_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
`ifdef PS2_TX_RETRY_EN
            retries_reg   <= retries_next;
`endif
        end
    end

    assign tx_ready_o = (state_reg == ST_IDLE);
    assign busy_o     = ~tx_ready_o;
    assign done_o     = done_reg;
    assign err_o      = err_reg;
    assign err_code_o = err_code_reg;

endmodule
